cpu_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the 32-bit core. Owns the PC, fetches from the
//  32-entry instruction memory, decodes ADD/SHIFTL/ADDI/SUBI/BEQ/J, and drives the

---
 rtl/cpu_control_fsm.sv | 159 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute, write-back, one instruction at a time.
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes trap into HALT instead of acting as NOPs.
module cpu_control_fsm #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_SHIFTL = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b000011;
  localparam logic [5:0] OP_SUBI   = 6'b000100;
  localparam logic [5:0] OP_BEQ    = 6'b000101;
  localparam logic [5:0] OP_J      = 6'b000110;

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   r_q;

  logic [5:0]          opcode;
  logic                is_rtype;
  logic                is_itype;
  logic                is_alu;
  logic                is_beq;
  logic                is_j;
  logic [4:0]          dest;
  logic [DATA_W-1:0]   simm;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_target;

  assign opcode    = ir[31:26];
  assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_SHIFTL);
  assign is_itype  = (opcode == OP_ADDI) || (opcode == OP_SUBI);
  assign is_alu    = is_rtype || is_itype;
  assign is_beq    = (opcode == OP_BEQ);
  assign is_j      = (opcode == OP_J);
  assign dest      = is_rtype ? ir[15:11] : ir[20:16];
  assign simm      = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign pc_inc    = pc + ADDR_W'(1);
  assign br_target = pc_inc + ir[ADDR_W-1:0];

  assign imem_addr = pc;
  assign rf_ra1    = ir[25:21];
  assign rf_ra2    = ir[20:16];
  assign rf_wd     = r_q;
  assign alu_a     = a_q;
  assign alu_b     = is_itype ? simm : b_q;
  assign busy      = (state != S_IDLE) && (state != S_HALT);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op = 2'd0;
    if (opcode == OP_SUBI)        alu_op = 2'd1;
    else if (opcode == OP_SHIFTL) alu_op = 2'd2;
  end

`ifndef ILLEGAL_TRAP_EN
  assign trap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only control and datapath registers are reset; the register file lives outside this block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      retired <= '0;
      rf_we   <= 1'b0;
      rf_wa   <= '0;
`ifdef ILLEGAL_TRAP_EN
      trap    <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          ir    <= imem_instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q   <= rf_rd1;
          b_q   <= rf_rd2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          r_q <= alu_result;
          if (is_alu) begin
            // Writes to r0 are suppressed here so WB never pulses rf_we for them.
            rf_we <= (dest != 5'd0);
            rf_wa <= dest;
            state <= S_WB;
          end else if (is_beq || is_j) begin
            if (is_j)            pc <= ir[ADDR_W-1:0];
            else if (a_q == b_q) pc <= br_target;
            else                 pc <= pc_inc;
            retired <= retired + CNT_W'(1);
            state   <= stop ? S_IDLE : S_FETCH;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            trap  <= 1'b1;
            state <= S_HALT;
`else
            pc      <= pc_inc;
            retired <= retired + CNT_W'(1);
            state   <= stop ? S_IDLE : S_FETCH;
`endif
          end
        end
        S_WB: begin
          pc      <= pc_inc;
          retired <= retired + CNT_W'(1);
          state   <= stop ? S_IDLE : S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: instruction memory, register file and ALU models
// around the DUT, plus an instruction-level reference model compared every cycle.
module tb_cpu_control_fsm;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic [4:0]        rf_ra1, rf_ra2, rf_wa;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
  logic              rf_we;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [ADDR_W-1:0] pc;
  logic              busy, trap;
  logic [CNT_W-1:0]  retired;

  logic [31:0] imem    [32];
  logic [31:0] rf      [32];
  logic [31:0] rf_init [32];
  logic        load_req = 1'b0;
  int          wr_count = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .busy(busy), .trap(trap), .retired(retired)
  );

  // Environment: combinational memory/register reads and the ALU.
  assign imem_instr = imem[imem_addr];
  assign rf_rd1     = rf[rf_ra1];
  assign rf_rd2     = rf[rf_ra2];

  always_comb begin
    case (alu_op)
      2'd0:    alu_result = alu_a + alu_b;
      2'd1:    alu_result = alu_a - alu_b;
      2'd2:    alu_result = alu_a << alu_b[4:0];
      default: alu_result = '0;
    endcase
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
    end else if (reset_n && rf_we) begin
      rf[rf_wa] <= rf_wd;
      wr_count  <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: architectural state plus a per-instruction cycle count.
  bit          m_run, m_halt, m_trap;
  int          m_phase;
  logic [4:0]  m_pc;
  logic [15:0] m_ret;
  logic [31:0] m_reg [32];

  function automatic void m_decode(input logic [31:0] ir, output int lat, output logic [4:0] dst,
                                   output logic [31:0] val, output logic [4:0] npc, output bit ill);
    logic [4:0]  rs, rt, seq;
    logic [31:0] simm;
    rs   = ir[25:21];
    rt   = ir[20:16];
    simm = {{16{ir[15]}}, ir[15:0]};
    seq  = m_pc + 5'd1;
    lat = 4; dst = 5'd0; val = '0; npc = seq; ill = 1'b0;
    case (ir[31:26])
      6'd0: begin dst = ir[15:11]; val = m_reg[rs] + m_reg[rt]; end
      6'd2: begin dst = ir[15:11]; val = m_reg[rs] << m_reg[rt][4:0]; end
      6'd3: begin dst = rt; val = m_reg[rs] + simm; end
      6'd4: begin dst = rt; val = m_reg[rs] - simm; end
      6'd5: begin lat = 3; if (m_reg[rs] == m_reg[rt]) npc = seq + ir[4:0]; end
      6'd6: begin lat = 3; npc = ir[4:0]; end
      default: begin lat = 3; ill = 1'b1; end
    endcase
  endfunction

  always @(negedge clk) begin
    int          lat;
    logic [4:0]  dst, npc;
    logic [31:0] val;
    bit          ill, exp_we;
    if (!reset_n) begin
      m_run = 0; m_halt = 0; m_trap = 0; m_phase = 0; m_pc = '0; m_ret = '0;
    end
    if (load_req) for (int i = 0; i < 32; i++) m_reg[i] = rf_init[i];
    m_decode(imem[m_pc], lat, dst, val, npc, ill);
    exp_we = m_run && (m_phase == 3) && (dst != 5'd0);
    check("busy", busy, m_run);
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("retired", retired, m_ret);
    check("trap", trap, m_trap);
    check("rf_we", rf_we, exp_we);
    if (exp_we) begin
      check("rf_wa", rf_wa, dst);
      check("rf_wd", rf_wd, val);
    end
    if (reset_n) begin
      if (!m_run) begin
        if (start && !m_halt) begin m_run = 1; m_phase = 0; end
      end else begin
        m_phase++;
`ifdef ILLEGAL_TRAP_EN
        if (ill && m_phase == 3) begin
          m_run = 0; m_halt = 1; m_trap = 1;
        end else
`endif
        if (m_phase == lat) begin
          if (lat == 4 && dst != 5'd0) m_reg[dst] = val;
          m_pc    = npc;
          m_ret   = m_ret + 16'd1;
          m_phase = 0;
          m_run   = !stop;
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    op = 6'd0;
      2:       op = 6'd2;
      3, 4:    op = 6'd3;
      5:       op = 6'd4;
      6, 7:    op = 6'd5;
      8:       op = 6'd6;
`ifdef ILLEGAL_TRAP_EN
      default: op = 6'd3;
`else
      default: op = 6'(7 + $urandom_range(0, 56));
`endif
    endcase
    w[31:26] = op;
    if (op == 6'd5 && $urandom_range(0, 1) == 1) w[20:16] = w[25:21];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_regs();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic step_one(output int lat);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin
      lat++;
      tick();
    end
    check("step_idle", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w;
    for (int i = 0; i < 32; i++) begin
      imem[i] = '0;
      rf_init[i] = '0;
    end
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_pc", pc, 5'd0);
    check("rst_retired", retired, 16'd0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_trap", trap, 1'b0);
    reset_n = 1'b1;
    load_regs();

    imem[0]  = enc_i(6'd3, 5'd0, 5'd10, 16'd10);
    imem[1]  = enc_i(6'd3, 5'd0, 5'd15, 16'd15);
    imem[2]  = enc_r(6'd0, 5'd10, 5'd15, 5'd25);
    imem[3]  = enc_i(6'd4, 5'd25, 5'd20, 16'd5);
    imem[4]  = enc_i(6'd3, 5'd0, 5'd0, 16'd5);
    imem[5]  = enc_i(6'd6, 5'd0, 5'd0, 16'd12);
    imem[12] = enc_i(6'd6, 5'd0, 5'd0, 16'd14);
    imem[14] = enc_i(6'd5, 5'd10, 5'd10, 16'd7);
    imem[22] = enc_i(6'd5, 5'd10, 5'd15, 16'd3);
    imem[23] = enc_i(6'd6, 5'd0, 5'd0, 16'd31);
    imem[31] = enc_i(6'd3, 5'd0, 5'd1, 16'd1);

    step_one(lat);
    check("addi_lat", lat, 4);
    check("addi_pc", pc, 5'd1);
    check("addi_retired", retired, 16'd1);
    check("r10", rf[10], 32'd10);
    step_one(lat);
    step_one(lat);
    check("r25", rf[25], 32'd25);
    step_one(lat);
    check("r20", rf[20], 32'd20);
    check("subi_pc", pc, 5'd4);
    w = wr_count;
    step_one(lat);
    check("r0_no_write", wr_count, w);
    check("r0_pc", pc, 5'd5);
    step_one(lat);
    check("j_lat", lat, 3);
    check("j_pc", pc, 5'd12);
    check("j_no_write", wr_count, w);
    step_one(lat);
    check("j14_pc", pc, 5'd14);
    step_one(lat);
    check("beq_taken_pc", pc, 5'd22);
    step_one(lat);
    check("beq_not_taken_pc", pc, 5'd23);
    step_one(lat);
    check("j31_pc", pc, 5'd31);
    step_one(lat);
    check("wrap_pc", pc, 5'd0);
    check("r1", rf[1], 32'd1);
    check("wrap_retired", retired, 16'd11);

    // Reset during WB of an ADD must abort the write.
    rf_init[1] = 32'd5;
    rf_init[2] = 32'd6;
    load_regs();
    imem[0] = enc_r(6'd0, 5'd1, 5'd2, 5'd3);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("wb_rf_we", rf_we, 1'b1);
    check("wb_rf_wd", rf_wd, 32'd11);
    w = wr_count;
    reset_n = 1'b0;
    #1;
    check("abort_pc", pc, 5'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_retired", retired, 16'd0);
    check("abort_rf_we", rf_we, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_no_write", wr_count, w);
    check("abort_r3", rf[3], 32'd0);

    imem[0] = 32'hFC00_0000;
    step_one(lat);
    check("illegal_lat", lat, 3);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_trap", trap, 1'b1);
    check("illegal_pc", pc, 5'd0);
    step_one(lat);
    check("halt_pc", pc, 5'd0);
    check("halt_trap", trap, 1'b1);
`else
    check("illegal_trap", trap, 1'b0);
    check("illegal_pc", pc, 5'd1);
    check("illegal_retired", retired, 16'd1);
    check("illegal_no_write", wr_count, w);
`endif

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      imem[i]    = rand_instr();
      rf_init[i] = (i == 0) ? 32'd0 : 32'($urandom_range(0, 7));
    end
    load_regs();
    stop = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) stop = ~stop;
      if (c == 2000) reset_n = 1'b0;
      if (c == 2003) reset_n = 1'b1;
      tick();
    end
    start = 1'b0;
    stop  = 1'b1;
    for (int c = 0; c < 20 && busy; c++) tick();
    check("final_idle", busy, 1'b0);
    tick();
    for (int i = 0; i < 32; i++) check($sformatf("final_r%0d", i), rf[i], m_reg[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
